sorted_priority_queue: RTL and testbench

Parametrised, fully sorted priority queue for the scheduler datapath. Each entry holds a tag (priority key) and a data payload. The best entry is always held in slot 0 and presented combinationally from registers, so the consumer can peek with zero latency. Insertion is single-cycle, by parallel compare-and-shift. Enqueue and dequeue may occur in the same cycle, and entries with equal tags leave in arrival order.

---
 rtl/sorted_pq_pkg.sv | 13 +
 rtl/sorted_pq_slot.sv | 41 ++++
 rtl/sorted_priority_queue.sv | 115 +++++++++++
 tb/tb_sorted_priority_queue.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/sorted_pq_pkg.sv
// Shared definitions for the sorted priority queue: key ordering and widths.
package sorted_pq_pkg;

    localparam int PQ_KEY_MAX_W = 64;

    // Strict ordering: equal keys never precede each other, which gives FIFO tie-break.
    function automatic logic precedes(input logic max_first,
                                      input logic [PQ_KEY_MAX_W-1:0] a,
                                      input logic [PQ_KEY_MAX_W-1:0] b);
        return max_first ? (a > b) : (a < b);
    endfunction

endpackage

// File: rtl/sorted_pq_slot.sv
// One queue slot: selects its next contents from hold, left, right or the new entry.
module sorted_pq_slot
    import sorted_pq_pkg::*;
#(
    parameter int SW    = 65,
    parameter bit FIRST = 1'b0
) (
    input  logic [SW-1:0] own,
    input  logic [SW-1:0] left,
    input  logic [SW-1:0] right,
    input  logic [SW-1:0] new_entry,
    input  logic          ins_self,
    input  logic          ins_prev,
    input  logic          ins_next,
    input  logic          enq_fire,
    input  logic          deq_fire,
    output logic [SW-1:0] nxt
);

    // ins is a thermometer (0..0 1..1), so neighbour flags locate this slot relative to p.
    always_comb begin
        nxt = own;
        unique case ({enq_fire, deq_fire})
            2'b10: begin
                if (ins_prev)
                    nxt = left;
                else if (ins_self)
                    nxt = new_entry;
            end
            2'b01: nxt = right;
            2'b11: begin
                if (!ins_next)
                    nxt = right;
                else if (!ins_self || FIRST)
                    nxt = new_entry;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/sorted_priority_queue.sv
// Fully sorted priority queue; best entry always in slot 0, single-cycle insert.
module sorted_priority_queue
    import sorted_pq_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 32,
    parameter int DEPTH      = 8,
    parameter bit MAX_FIRST  = 1'b0
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic                       flush,
    input  logic                       enq_valid,
    output logic                       enq_ready,
    input  logic [TAG_WIDTH-1:0]       enq_tag,
    input  logic [DATA_WIDTH-1:0]      enq_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [TAG_WIDTH-1:0]       out_tag,
    output logic [DATA_WIDTH-1:0]      out_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int SW = 1 + TAG_WIDTH + DATA_WIDTH;
    localparam int CW = $clog2(DEPTH+1);

    typedef struct packed {
        logic                  valid;
        logic [TAG_WIDTH-1:0]  tag;
        logic [DATA_WIDTH-1:0] data;
    } slot_t;

    slot_t            slot_q  [DEPTH];
    slot_t            slot_d  [DEPTH];
    slot_t            left_q  [DEPTH];
    slot_t            right_q [DEPTH];
    slot_t            new_entry;
    logic [DEPTH-1:0] ins;
    logic [DEPTH-1:0] ins_prev;
    logic [DEPTH-1:0] ins_next;
    logic             enq_fire;
    logic             deq_fire;

    assign new_entry = '{valid: 1'b1, tag: enq_tag, data: enq_data};

    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    // Combinational path from out_ready: a full queue accepts when the head leaves.
    assign enq_ready = !full || out_ready;
    assign out_valid = slot_q[0].valid;
    assign out_tag   = slot_q[0].tag;
    assign out_data  = slot_q[0].data;
    assign enq_fire  = enq_valid && enq_ready;
    assign deq_fire  = out_valid && out_ready;

    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        assign ins[i] = !slot_q[i].valid ||
                        precedes(MAX_FIRST, PQ_KEY_MAX_W'(enq_tag), PQ_KEY_MAX_W'(slot_q[i].tag));

        if (i == 0) begin : g_left_edge
            assign left_q[i]   = '0;
            assign ins_prev[i] = 1'b0;
        end else begin : g_left
            assign left_q[i]   = slot_q[i-1];
            assign ins_prev[i] = ins[i-1];
        end

        // Beyond the last slot the queue behaves as an empty (always-insertable) slot.
        if (i == DEPTH-1) begin : g_right_edge
            assign right_q[i]  = '0;
            assign ins_next[i] = 1'b1;
        end else begin : g_right
            assign right_q[i]  = slot_q[i+1];
            assign ins_next[i] = ins[i+1];
        end

        sorted_pq_slot #(
            .SW    (SW),
            .FIRST (i == 0)
        ) u_slot (
            .own       (slot_q[i]),
            .left      (left_q[i]),
            .right     (right_q[i]),
            .new_entry (new_entry),
            .ins_self  (ins[i]),
            .ins_prev  (ins_prev[i]),
            .ins_next  (ins_next[i]),
            .enq_fire  (enq_fire),
            .deq_fire  (deq_fire),
            .nxt       (slot_d[i])
        );
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < DEPTH; i++)
                slot_q[i] <= '0;
            count <= '0;
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++)
                slot_q[i] <= '0;
            count <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++)
                slot_q[i] <= slot_d[i];
            if (enq_fire && !deq_fire)
                count <= count + CW'(1);
            else if (deq_fire && !enq_fire)
                count <= count - CW'(1);
        end
    end

endmodule

// File: tb/tb_sorted_priority_queue.sv
// Bench for sorted_priority_queue: MIN and MAX instances checked against a queue-based model.
module tb_sorted_priority_queue;

    localparam int D  = 4;
    localparam int TW = 8;
    localparam int DW = 16;

    logic          clk_in = 1'b0;
    logic          rst_in = 1'b1;
    logic          flush = 1'b0;
    logic          enq_valid = 1'b0;
    logic [TW-1:0] enq_tag = '0;
    logic [DW-1:0] enq_data = '0;
    logic          out_ready = 1'b0;

    logic          mn_enq_ready, mn_out_valid, mn_full, mn_empty;
    logic [TW-1:0] mn_out_tag;
    logic [DW-1:0] mn_out_data;
    logic [2:0]    mn_count;
    logic          mx_enq_ready, mx_out_valid, mx_full, mx_empty;
    logic [TW-1:0] mx_out_tag;
    logic [DW-1:0] mx_out_data;
    logic [2:0]    mx_count;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [TW-1:0] tag;
        logic [DW-1:0] data;
    } ent_t;

    ent_t qmn[$];
    ent_t qmx[$];

    always #5 clk_in = ~clk_in;

    sorted_priority_queue #(.DATA_WIDTH(DW), .TAG_WIDTH(TW), .DEPTH(D), .MAX_FIRST(1'b0)) dut_min (
        .clk_in(clk_in), .rst_in(rst_in), .flush(flush),
        .enq_valid(enq_valid), .enq_ready(mn_enq_ready), .enq_tag(enq_tag), .enq_data(enq_data),
        .out_valid(mn_out_valid), .out_ready(out_ready), .out_tag(mn_out_tag), .out_data(mn_out_data),
        .count(mn_count), .full(mn_full), .empty(mn_empty)
    );

    sorted_priority_queue #(.DATA_WIDTH(DW), .TAG_WIDTH(TW), .DEPTH(D), .MAX_FIRST(1'b1)) dut_max (
        .clk_in(clk_in), .rst_in(rst_in), .flush(flush),
        .enq_valid(enq_valid), .enq_ready(mx_enq_ready), .enq_tag(enq_tag), .enq_data(enq_data),
        .out_valid(mx_out_valid), .out_ready(out_ready), .out_tag(mx_out_tag), .out_data(mx_out_data),
        .count(mx_count), .full(mx_full), .empty(mx_empty)
    );

    // Head = first-arrived entry among those with the best tag.
    function automatic int head_mn();
        int h = 0;
        for (int i = 1; i < qmn.size(); i++)
            if (qmn[i].tag < qmn[h].tag) h = i;
        return h;
    endfunction

    function automatic int head_mx();
        int h = 0;
        for (int i = 1; i < qmx.size(); i++)
            if (qmx[i].tag > qmx[h].tag) h = i;
        return h;
    endfunction

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic precheck();
        int h;
        chk("min.out_valid", 32'(mn_out_valid), 32'(qmn.size() > 0));
        chk("min.count",     32'(mn_count),     32'(qmn.size()));
        chk("min.full",      32'(mn_full),      32'(qmn.size() == D));
        chk("min.empty",     32'(mn_empty),     32'(qmn.size() == 0));
        chk("min.enq_ready", 32'(mn_enq_ready), 32'(qmn.size() < D || out_ready));
        if (qmn.size() > 0) begin
            h = head_mn();
            chk("min.out_tag",  32'(mn_out_tag),  32'(qmn[h].tag));
            chk("min.out_data", 32'(mn_out_data), 32'(qmn[h].data));
        end
        chk("max.out_valid", 32'(mx_out_valid), 32'(qmx.size() > 0));
        chk("max.count",     32'(mx_count),     32'(qmx.size()));
        chk("max.full",      32'(mx_full),      32'(qmx.size() == D));
        chk("max.empty",     32'(mx_empty),     32'(qmx.size() == 0));
        chk("max.enq_ready", 32'(mx_enq_ready), 32'(qmx.size() < D || out_ready));
        if (qmx.size() > 0) begin
            h = head_mx();
            chk("max.out_tag",  32'(mx_out_tag),  32'(qmx[h].tag));
            chk("max.out_data", 32'(mx_out_data), 32'(qmx[h].data));
        end
    endtask

    // One clock: drive, check pre-edge outputs, advance the model, cross the edge.
    task automatic step(input bit ev, input logic [TW-1:0] tg, input logic [DW-1:0] dt,
                        input bit ordy, input bit fl);
        bit   acc;
        ent_t e;
        enq_valid = ev; enq_tag = tg; enq_data = dt; out_ready = ordy; flush = fl;
        #1;
        precheck();
        e.tag = tg; e.data = dt;
        if (fl) begin
            qmn.delete(); qmx.delete();
        end else begin
            acc = ev && (qmn.size() < D || ordy);
            if (ordy && qmn.size() > 0) begin
                qmn.delete(head_mn());
                qmx.delete(head_mx());
            end
            if (acc) begin
                qmn.push_back(e);
                qmx.push_back(e);
            end
        end
        @(posedge clk_in);
        #1;
    endtask

    logic [TW-1:0] exp_tag [4];
    logic [DW-1:0] exp_dat [4];

    initial begin
        // Reset values
        @(posedge clk_in);
        #1;
        chk("rst.out_tag",  32'(mn_out_tag),  32'h0);
        chk("rst.out_data", 32'(mn_out_data), 32'h0);
        precheck();
        rst_in = 1'b0;

        // MIN: 5,2,9,2 -> B(2), D(2), A(5), C(9)
        step(1, 8'd5, 16'hA, 0, 0);
        step(1, 8'd2, 16'hB, 0, 0);
        step(1, 8'd9, 16'hC, 0, 0);
        step(1, 8'd2, 16'hD, 0, 0);
        chk("dir1.max_head", 32'(mx_out_tag), 32'd9);
        step(1, 8'd3, 16'hE, 0, 0);
        chk("dir1.full_hold", 32'(mn_count), 32'd4);
        exp_tag = '{8'd2, 8'd2, 8'd5, 8'd9};
        exp_dat = '{16'hB, 16'hD, 16'hA, 16'hC};
        for (int i = 0; i < 4; i++) begin
            chk("dir1.tag",  32'(mn_out_tag),  32'(exp_tag[i]));
            chk("dir1.data", 32'(mn_out_data), 32'(exp_dat[i]));
            step(0, 8'd0, 16'h0, 1, 0);
        end

        // Full swap: 10,20,30,40 then enqueue 15 with a concurrent dequeue
        step(1, 8'd10, 16'h1, 0, 0);
        step(1, 8'd20, 16'h2, 0, 0);
        step(1, 8'd30, 16'h3, 0, 0);
        step(1, 8'd40, 16'h4, 0, 0);
        chk("dir2.head_pre", 32'(mn_out_tag), 32'd10);
        step(1, 8'd15, 16'h15, 1, 0);
        chk("dir2.count", 32'(mn_count), 32'd4);
        exp_tag = '{8'd15, 8'd20, 8'd30, 8'd40};
        for (int i = 0; i < 4; i++) begin
            chk("dir2.tag", 32'(mn_out_tag), 32'(exp_tag[i]));
            step(0, 8'd0, 16'h0, 1, 0);
        end

        // MAX: 3,7,7,1 -> 7(first), 7(second), 3, 1
        step(1, 8'd3, 16'h31, 0, 0);
        step(1, 8'd7, 16'h71, 0, 0);
        step(1, 8'd7, 16'h72, 0, 0);
        step(1, 8'd1, 16'h11, 0, 0);
        exp_tag = '{8'd7, 8'd7, 8'd3, 8'd1};
        exp_dat = '{16'h71, 16'h72, 16'h31, 16'h11};
        for (int i = 0; i < 4; i++) begin
            chk("dir3.tag",  32'(mx_out_tag),  32'(exp_tag[i]));
            chk("dir3.data", 32'(mx_out_data), 32'(exp_dat[i]));
            step(0, 8'd0, 16'h0, 1, 0);
        end

        // Empty with enq and out_ready together
        step(1, 8'd4, 16'h44, 1, 0);
        chk("dir4.valid", 32'(mn_out_valid), 32'd1);
        chk("dir4.tag",   32'(mn_out_tag),   32'd4);
        step(0, 8'd0, 16'h0, 1, 0);

        // Flush with three entries and a concurrent enqueue
        step(1, 8'd6, 16'h61, 0, 0);
        step(1, 8'd2, 16'h21, 0, 0);
        step(1, 8'd8, 16'h81, 0, 0);
        step(1, 8'd1, 16'h12, 1, 1);
        chk("dir5.count", 32'(mn_count), 32'd0);
        chk("dir5.empty", 32'(mn_empty), 32'd1);

        // Random traffic with one asynchronous reset mid-stream
        for (int n = 0; n < 600; n++) begin
            if (n == 300) begin
                enq_valid = 1'b1; out_ready = 1'b0; flush = 1'b0;
                #2 rst_in = 1'b1;
                #1;
                chk("rst.count", 32'(mn_count),     32'd0);
                chk("rst.empty", 32'(mx_empty),     32'd1);
                chk("rst.valid", 32'(mn_out_valid), 32'd0);
                qmn.delete(); qmx.delete();
                @(posedge clk_in);
                #1 rst_in = 1'b0;
            end
            step(($urandom_range(0, 3) != 0), TW'($urandom_range(0, 15)), DW'($urandom),
                 ($urandom_range(0, 2) == 0), ($urandom_range(0, 39) == 0));
        end
        precheck();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
